camera_emulator: RTL and testbench

- Transmit-side model of the OV7670-style parallel camera interface: generates pclk, vsync, href and 8-bit RGB565 byte data that a camera_read receiver samples.
- Replaces the physical camera on the JA/JB pins for bring-up and for closed-loop receiver/frame-buffer testing.
- Output is a configurable test pattern.

---
 rtl/camera_emulator.sv | 185 ++++++++++++++++++
 tb/tb_camera_emulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/camera_emulator.sv
// Transmit-side model of an OV7670-style parallel camera: pclk at clk/2, with vsync,
// href and RGB565 bytes driven on the pclk falling edge from a selectable test pattern.
module camera_emulator #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int L    = 2 * H_ACTIVE + H_BLANK;
  localparam int SW   = $clog2(L);
  localparam int NL   = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int LW   = $clog2(NL + 1);
  localparam int BARW = H_ACTIVE / 8;
  localparam int SUBW = (BARW > 1) ? $clog2(BARW) : 1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [LW-1:0]   line_q, line_d;
  logic [1:0]      pat_q, pat_d;
  logic [2:0]      bar_q, bar_d;
  logic [SUBW-1:0] sub_q, sub_d;
  logic            pclk_q, pclk_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      data_q, data_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      frame_count_q, frame_count_d;

  logic [LW-1:0]   last_line;
  logic            slot_end;
  logic [15:0]     x16, y16, pix;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    line_d        = line_q;
    pat_d         = pat_q;
    bar_d         = bar_q;
    sub_d         = sub_q;
    pclk_d        = ~pclk_q;
    vsync_d       = vsync_q;
    href_d        = href_q;
    data_d        = data_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    last_line     = '0;
    slot_end      = (slot_q == SW'(L - 1));
    x16           = '0;
    y16           = '0;
    pix           = '0;

    case (state_q)
      VSYNC:   last_line = LW'(VSYNC_LINES - 1);
      VBACK:   last_line = LW'(V_BACK - 1);
      ACTIVE:  last_line = LW'(V_ACTIVE - 1);
      default: last_line = LW'(V_FRONT - 1);
    endcase

    // Everything except pclk advances only on the edge that drives pclk low.
    if (pclk_q) begin
      if (state_q == IDLE) begin
        if (enable) begin
          state_d = VSYNC;
          pat_d   = pattern_sel;
          slot_d  = '0;
          line_d  = '0;
        end
      end else begin
        slot_d = slot_end ? '0 : slot_q + 1'b1;
        if (slot_end) begin
          line_d = line_q + 1'b1;
          if (line_q == last_line) begin
            line_d = '0;
            case (state_q)
              VSYNC:   state_d = VBACK;
              VBACK:   state_d = ACTIVE;
              ACTIVE:  state_d = VFRONT;
              default: begin
                state_d = enable ? VSYNC : IDLE;
                if (enable) pat_d = pattern_sel;
              end
            endcase
          end
        end
      end

      if (state_q == ACTIVE && line_q == LW'(V_ACTIVE - 1) &&
          slot_q == SW'(2 * H_ACTIVE - 1)) begin
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
      end

      // Bar index tracks the pixel of slot_d by counting H_ACTIVE/8 pixels per bar.
      if (slot_d == '0) begin
        bar_d = '0;
        sub_d = '0;
      end else if (!slot_d[0] && slot_d < SW'(2 * H_ACTIVE)) begin
        if (sub_q == SUBW'(BARW - 1)) begin
          sub_d = '0;
          bar_d = bar_q + 3'd1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end

      x16 = 16'(slot_d >> 1);
      y16 = 16'(line_d);
      case (pat_q)
        2'd0: begin
          case (bar_d)
            3'd0:    pix = 16'hFFFF;
            3'd1:    pix = 16'hFFE0;
            3'd2:    pix = 16'h07FF;
            3'd3:    pix = 16'h07E0;
            3'd4:    pix = 16'hF81F;
            3'd5:    pix = 16'hF800;
            3'd6:    pix = 16'h001F;
            default: pix = 16'h0000;
          endcase
        end
        2'd1:    pix = {x16[4:0], x16[5:0], x16[4:0]};
        2'd2:    pix = (x16[3] ^ y16[3]) ? 16'hFFFF : 16'h0000;
        default: pix = x16 + y16;
      endcase

      vsync_d = (state_d == VSYNC);
      href_d  = (state_d == ACTIVE) && (slot_d < SW'(2 * H_ACTIVE));
      data_d  = href_d ? (slot_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      line_q        <= '0;
      pat_q         <= '0;
      bar_q         <= '0;
      sub_q         <= '0;
      pclk_q        <= 1'b0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'h00;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      line_q        <= line_d;
      pat_q         <= pat_d;
      bar_q         <= bar_d;
      sub_q         <= sub_d;
      pclk_q        <= pclk_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data_q        <= data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pclk        = pclk_q;
  assign vsync       = vsync_q;
  assign href        = href_q;
  assign data        = data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_camera_emulator.sv
// Bench for camera_emulator: per-slot comparison of pclk/vsync/href/data against a
// frame model built from the line/frame geometry, plus abort, idle and wrap checks.
module tb_camera_emulator;

  localparam int HA = 16, HB = 4, VA = 4, VS = 1, VB = 1, VF = 1;
  localparam int L  = 2 * HA + HB;
  localparam int FR = (VS + VB + VA + VF) * L;
  localparam int K0 = (VS + VB + VA - 1) * L + 2 * HA;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [1:0] pattern_sel;
  logic       pclk, vsync, href, frame_done;
  logic [7:0] data, frame_count;

  logic       reset2, enable2;
  logic       pclk2, vsync2, href2, frame_done2;
  logic [7:0] data2, frame_count2;

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  camera_emulator #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
                    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .frame_done(frame_done), .frame_count(frame_count));

  // Tiny geometry so that 256 frames fit in a short run.
  camera_emulator #(.H_ACTIVE(8), .H_BLANK(1), .V_ACTIVE(1),
                    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut_wrap (
    .clk(clk), .reset(reset2), .enable(enable2), .pattern_sel(2'd1),
    .pclk(pclk2), .vsync(vsync2), .href(href2), .data(data2),
    .frame_done(frame_done2), .frame_count(frame_count2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {vsync, href, data} for slot k of a frame drawn with pattern p.
  function automatic logic [9:0] exp_slot(input int p, input int k);
    int line, s, y;
    logic [15:0] x, yy, pix;
    line = k / L;
    s    = k % L;
    y    = line - (VS + VB);
    if (line < VS) return {1'b1, 1'b0, 8'h00};
    if (y < 0 || y >= VA || s >= 2 * HA) return 10'h000;
    x  = 16'(s / 2);
    yy = 16'(y);
    case (p)
      0: begin
        case (s / 2 / (HA / 8))
          0: pix = 16'hFFFF;  1: pix = 16'hFFE0;
          2: pix = 16'h07FF;  3: pix = 16'h07E0;
          4: pix = 16'hF81F;  5: pix = 16'hF800;
          6: pix = 16'h001F;  default: pix = 16'h0000;
        endcase
      end
      1: pix = {x[4:0], x[5:0], x[4:0]};
      2: pix = ((((s / 2) / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      default: pix = x + yy;
    endcase
    return {1'b0, 1'b1, (s % 2 == 0) ? pix[15:8] : pix[7:0]};
  endfunction

  task automatic run_frame(input int p, input int pnext, input bit drop);
    int n = 0;
    int fd_cnt = 0;
    int fd_k = -1;
    while (vsync !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (vsync !== 1'b1) begin
      check("vsync_start", 32'(vsync), 32'd1);
      return;
    end
    for (int k = 0; k < FR; k++) begin
      if (k == 2 * L) pattern_sel = 2'($urandom);
      if (k == FR - 5) pattern_sel = 2'(pnext);
      if (drop && k == (VS + VB + 1) * L + 5) enable = 1'b0;
      @(negedge clk);
      check($sformatf("p%0d_slot%0d", p, k), {21'd0, pclk, vsync, href, data},
            {21'd0, 1'b1, exp_slot(p, k)});
      if (frame_done) fd_cnt++;
      @(negedge clk);
      if (frame_done) begin
        fd_cnt++;
        fd_k = k + 1;
      end
    end
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    check("frame_done_pos", 32'(fd_k), 32'(K0));
    exp_fc = (exp_fc + 1) % 256;
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    if (!drop) check("next_vsync", 32'(vsync), 32'd1);
  endtask

  initial begin
    int pats[5];
    int n, cnt;
    reset = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    reset2 = 1'b0; enable2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {22'd0, pclk, vsync, href, data, frame_done},
          32'd0);
    check("reset_count", 32'(frame_count), 32'd0);
    reset = 1'b1;

    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), {21'd0, pclk, vsync, href, data},
            {21'd0, (i % 2 == 1), 10'h000});
    end
    check("idle_count", 32'(frame_count), 32'd0);

    pats[0] = 0; pats[1] = 2; pats[2] = 3;
    pats[3] = int'($urandom_range(0, 3)); pats[4] = int'($urandom_range(0, 3));
    pattern_sel = 2'd0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      $display("frame pattern=%0d drop=%0d", pats[i], (i == 4));
      run_frame(pats[i], (i < 4) ? pats[i + 1] : 0, (i == 4));
    end

    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vsync) cnt++;
    end
    check("idle_after_drop", 32'(cnt), 32'd0);

    pattern_sel = 2'd3;
    enable = 1'b1;
    n = 0;
    while (href !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("href_before_abort", 32'(href), 32'd1);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("abort_outputs", {14'd0, pclk, vsync, href, data, frame_done, frame_count},
             32'd0);
    @(negedge clk);
    check("abort_held", {14'd0, pclk, vsync, href, data, frame_done, frame_count}, 32'd0);
    reset = 1'b1;
    exp_fc = 0;
    $display("frame pattern=3 after abort");
    run_frame(3, 3, 1'b0);

    reset2 = 1'b1;
    enable2 = 1'b1;
    n = 0; cnt = 0;
    while (cnt < 256 && n < 60000) begin
      @(negedge clk);
      n++;
      if (frame_done2) begin
        cnt++;
        if (cnt == 1 || cnt == 255 || cnt == 256)
          check($sformatf("wrap_count%0d", cnt), 32'(frame_count2), 32'(cnt % 256));
      end
    end
    check("wrap_frames", 32'(cnt), 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
